alu_rr_scheduler: RTL and testbench
===================================

ALU_RR_SCHEDULER -- requirements
Module: alu_rr_scheduler

Interface
REQ-001 Parameter WIDTH: default 16; operand and result width; the only supported value is 16.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  bit i set means requester i presents an operation.
REQ-005 req_ready  output  2  bit i set means the scheduler accepts requester i this cycle.
REQ-006 req_opcode  input  8  packed as {op1[3:0], op0[3:0]}; codes 0 XOR, 1 SRL, 2 SGT, 3 XNOR, 4 AND, 5 SUB, 6 OR, 7 SNE, 8 DIV, 9 SLT.
REQ-007 req_a  input  32  packed input1 operands, requester 1 in the upper half.
REQ-008 req_b  input  32  packed input2 operands, requester 1 in the upper half.
REQ-009 req_shamt  input  10  packed 5-bit SRL shift amounts, requester 1 in the upper half.
REQ-010 rsp_valid  output  1  response held valid.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 rsp_id  output  1  index of the requester that owns the response.
REQ-013 rsp_result  output  16  operation result.
REQ-014 rsp_carry, rsp_zero, rsp_sign  output  1 each  result flags.
REQ-015 rsp_err  output  1  illegal opcode indicator.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, DIV_BUSY and RESP; only one operation is in flight at a time.
REQ-017 In IDLE, req_ready SHALL be one-hot to the granted requester when any req_valid is set, and 0 otherwise. In all other states req_ready SHALL be 0.
REQ-018 Arbitration SHALL be round-robin.
  - Single valid requester: it is granted.
  - Both valid: the requester not granted last time wins.
  - After reset: requester 0 wins the first tie.
REQ-019 On a handshake (req_valid[i] and req_ready[i]), the scheduler SHALL latch the opcode, operands, shift amount and id, and move to DIV_BUSY for opcode 8 or to EXEC otherwise.
REQ-020 EXEC SHALL compute the result in one cycle, register the result and flags, and move to RESP. rsp_valid SHALL rise on the 2nd rising edge after acceptance.
REQ-021 DIV_BUSY SHALL run a 16-iteration restoring divide (quotient only) and then move to RESP. rsp_valid SHALL rise on the 17th rising edge after acceptance.
REQ-022 Divide by zero SHALL give result 0x0000 with unchanged latency.
REQ-023 SGT and SLT SHALL be signed compares; SNE SHALL be an inequality test. Each SHALL return 0x0001 when true and 0x0000 when false.
REQ-024 SRL SHALL be a logical right shift of a by shamt; shamt values of 16 or more SHALL give 0.
REQ-025 Flag rules:
  - rsp_carry SHALL be the SUB borrow (a < b unsigned) and 0 for every other op.
  - rsp_zero SHALL equal (result == 0).
  - rsp_sign SHALL equal result[15].
REQ-026 Opcodes 10–15 SHALL give result 0, rsp_err 1 and EXEC-path latency. rsp_err SHALL be 0 for legal opcodes.
REQ-027 In RESP, all rsp_* outputs SHALL hold stable until rsp_ready. The scheduler SHALL return to IDLE on the handshake edge, and the next acceptance occurs no earlier than the following cycle.
REQ-028 Requester inputs SHALL be ignored outside IDLE. A req_valid may drop without penalty before it is granted.

Reset
REQ-029 While rst_n is low, the scheduler SHALL clear immediately to IDLE with the following values:
  - req_ready = 0, rsp_valid = 0.
  - rsp_result, rsp_id and all rsp flags = 0.
  - Divider state cleared; round-robin pointer set to favour requester 0.
REQ-030 Reset during EXEC, DIV_BUSY or RESP SHALL discard the in-flight operation, and no response for it SHALL ever be emitted.

Configuration
REQ-031 Macro ALU_SCHED_DIV_EN:
  - Defined: the DIV_BUSY state and the divider SHALL be built and opcode 8 executes as in REQ-021.
  - Undefined: no divider logic SHALL exist and opcode 8 SHALL be handled as an illegal opcode per REQ-026.

Verification
REQ-032 Requester 0 SUB, a=0x0003, b=0x0005 -> after 2 edges: result 0xFFFE, carry 1, sign 1, zero 0, id 0.
REQ-033 Both requesters valid for 4 back-to-back ops with rsp_ready held at 1 -> grant order 0,1,0,1.
REQ-034 DIV cases with macro defined:
  - 0x0064 / 0x0007 -> 0x000E after 17 edges.
  - 0x1234 / 0x0000 -> 0x0000 with zero 1.
REQ-035 SLT 0x8000 vs 0x0001 -> 0x0001. SGT with the same operands -> 0x0000. Opcode 0xC -> result 0 with err 1.
REQ-036 rsp_ready held low for 5 cycles -> rsp_* stable throughout and req_ready 0. rst_n pulsed low mid-DIV -> no rsp_valid afterwards and all outputs 0.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
// Two-requester round-robin front end for a small 16-bit ALU. Exactly one
// operation is in flight at a time: it is accepted in IDLE, executed in EXEC
// (single cycle) or DIV_BUSY (16-step restoring divide), then held in RESP
// until the consumer takes it.
//
// Build option: define ALU_SCHED_DIV_EN to build the divider and the DIV_BUSY
// state. Without it, opcode 8 is treated as an illegal opcode.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid[1:0]  per-requester operation present
//   req_ready[1:0]  one-hot grant (IDLE only)
//   req_opcode[7:0] {op1, op0}
//   req_a/req_b     {requester1, requester0} 16-bit operands
//   req_shamt[9:0]  {sh1, sh0} 5-bit SRL shift amounts
//   rsp_valid       response held valid
//   rsp_ready       consumer accepts response
//   rsp_id          owning requester
//   rsp_result      16-bit result
//   rsp_carry/zero/sign/err  result flags
// ---------------------------------------------------------------------------
module alu_rr_scheduler #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [7:0]           req_opcode,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [9:0]           req_shamt,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [WIDTH-1:0]     rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_zero,
    output logic                 rsp_sign,
    output logic                 rsp_err
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_EXEC     = 2'd1;
`ifdef ALU_SCHED_DIV_EN
    localparam logic [1:0] S_DIV_BUSY = 2'd2;
    localparam logic [3:0] OP_DIV     = 4'd8;
`endif
    localparam logic [1:0] S_RESP     = 2'd3;

    localparam logic [3:0] OP_XOR  = 4'd0;
    localparam logic [3:0] OP_SRL  = 4'd1;
    localparam logic [3:0] OP_SGT  = 4'd2;
    localparam logic [3:0] OP_XNOR = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_SNE  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd9;

    logic [1:0]       r_state;
    logic             r_last_id;     // requester granted most recently
    logic             r_id;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [4:0]       r_shamt;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_sign;
    logic             r_err;

    logic             w_grant_id;
    logic             w_accept;
    logic [3:0]       w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [4:0]       w_sel_shamt;
    logic [WIDTH+1:0] w_exec;

    // Returns {err, carry, result} for every single-cycle opcode.
    function automatic logic [WIDTH+1:0] alu_eval(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [4:0]       sh
    );
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             err;
        res   = '0;
        carry = 1'b0;
        err   = 1'b0;
        case (op)
            OP_XOR:  res = a ^ b;
            OP_SRL:  res = (sh >= 5'd16) ? '0 : (a >> sh);
            OP_SGT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
            OP_XNOR: res = ~(a ^ b);
            OP_AND:  res = a & b;
            OP_SUB: begin
                res   = a - b;
                carry = (a < b);
            end
            OP_OR:   res = a | b;
            OP_SNE:  res = {{(WIDTH-1){1'b0}}, (a != b)};
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: err = 1'b1;
        endcase
        return {err, carry, res};
    endfunction

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        case (req_valid)
            2'b10:   w_grant_id = 1'b1;
            2'b11:   w_grant_id = ~r_last_id;
            default: w_grant_id = 1'b0;
        endcase
    end

    // Grant is also forced low while reset is asserted.
    assign req_ready = (rst_n && (r_state == S_IDLE) && (req_valid != 2'b00))
                       ? (w_grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign w_accept  = |req_ready;

    assign w_sel_op    = w_grant_id ? req_opcode[7:4]        : req_opcode[3:0];
    assign w_sel_a     = w_grant_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign w_sel_b     = w_grant_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    assign w_sel_shamt = w_grant_id ? req_shamt[9:5]         : req_shamt[4:0];

    assign w_exec = alu_eval(r_op, r_a, r_b, r_shamt);

`ifdef ALU_SCHED_DIV_EN
    logic [3:0]       r_div_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;        // dividend shifts out as quotient shifts in
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_div_res;

    always_comb begin
        w_rem_sh = {r_rem, r_quo[WIDTH-1]};
        w_diff   = w_rem_sh - {1'b0, r_b};
        if (w_diff[WIDTH]) begin
            w_rem_next = w_rem_sh[WIDTH-1:0];
            w_quo_next = {r_quo[WIDTH-2:0], 1'b0};
        end else begin
            w_rem_next = w_diff[WIDTH-1:0];
            w_quo_next = {r_quo[WIDTH-2:0], 1'b1};
        end
    end

    // A zero divisor would yield all ones; it is reported as zero instead.
    assign w_div_res = (r_b == '0) ? '0 : w_quo_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
        end else if (w_accept) begin
            r_div_cnt <= '0;
            r_rem     <= '0;
            r_quo     <= w_sel_a;
        end else if (r_state == S_DIV_BUSY) begin
            r_div_cnt <= r_div_cnt + 4'd1;
            r_rem     <= w_rem_next;
            r_quo     <= w_quo_next;
        end
    end
`endif

    // Operand capture at acceptance
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op    <= w_sel_op;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_shamt <= w_sel_shamt;
        end
    end

    // Control and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_last_id <= 1'b1;
            r_id      <= 1'b0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_sign    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id      <= w_grant_id;
                        r_last_id <= w_grant_id;
`ifdef ALU_SCHED_DIV_EN
                        r_state   <= (w_sel_op == OP_DIV) ? S_DIV_BUSY : S_EXEC;
`else
                        r_state   <= S_EXEC;
`endif
                    end
                end
                S_EXEC: begin
                    r_result <= w_exec[WIDTH-1:0];
                    r_carry  <= w_exec[WIDTH];
                    r_err    <= w_exec[WIDTH+1];
                    r_zero   <= (w_exec[WIDTH-1:0] == '0);
                    r_sign   <= w_exec[WIDTH-1];
                    r_state  <= S_RESP;
                end
`ifdef ALU_SCHED_DIV_EN
                S_DIV_BUSY: begin
                    if (r_div_cnt == 4'd15) begin
                        r_result <= w_div_res;
                        r_carry  <= 1'b0;
                        r_err    <= 1'b0;
                        r_zero   <= (w_div_res == '0);
                        r_sign   <= w_div_res[WIDTH-1];
                        r_state  <= S_RESP;
                    end
                end
`endif
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_carry  = r_carry;
    assign rsp_zero   = r_zero;
    assign rsp_sign   = r_sign;
    assign rsp_err    = r_err;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_scheduler
// Self-checking bench for alu_rr_scheduler: a table of hand-computed vectors,
// hand-written sequences for arbitration, back-pressure and reset, and
// randomized traffic checked against an arithmetic reference model.
// Honors ALU_SCHED_DIV_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_alu_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_opcode;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [9:0]  req_shamt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_zero;
    logic        rsp_sign;
    logic        rsp_err;

    alu_rr_scheduler #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_shamt  (req_shamt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .rsp_sign   (rsp_sign),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  vm;     // which requester presents the op
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  sh;
        logic [15:0] res;
        logic [3:0]  fl;     // {carry, zero, sign, err}
        int          lat;    // edges from acceptance edge (counted as 1) to rsp_valid
    } vec_t;

    localparam int NV = 18;
    vec_t tbl[NV];

    int n_vec = 0;
    int n_err = 0;
    bit m_last;              // model of the last granted requester

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: {id, carry, zero, sign, err, result} plus latency.
    function automatic logic [20:0] model(input bit id, input logic [3:0] op,
                                          input logic [15:0] a, input logic [15:0] b,
                                          input logic [4:0] sh, output int lat);
        int ua, ub, sa, sb;
        logic [15:0] r;
        logic c, e;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        r = 16'h0; c = 1'b0; e = 1'b0; lat = 2;
        case (op)
            4'd0: r = a ^ b;
            4'd1: r = (sh > 5'd15) ? 16'h0 : 16'(ua / (1 << sh));
            4'd2: r = (sa > sb) ? 16'd1 : 16'd0;
            4'd3: r = ~(a ^ b);
            4'd4: r = a & b;
            4'd5: begin r = 16'(ua - ub); c = (ua < ub); end
            4'd6: r = a | b;
            4'd7: r = (a != b) ? 16'd1 : 16'd0;
`ifdef ALU_SCHED_DIV_EN
            4'd8: begin lat = 17; r = (ub == 0) ? 16'h0 : 16'(ua / ub); end
`endif
            4'd9: r = (sa < sb) ? 16'd1 : 16'd0;
            default: e = 1'b1;
        endcase
        return {id, c, (r == 16'h0), r[15], e, r};
    endfunction

    // Presents one operation, waits (bounded) for the response, then takes it.
    // Entered and left #1 after a rising edge.
    task automatic run_txn(input logic [1:0] vm, input logic [7:0] opc,
                           input logic [31:0] a, input logic [31:0] b, input logic [9:0] sh,
                           output logic [1:0] rdy, output logic [20:0] got, output int edges);
        req_opcode = opc;
        req_a      = a;
        req_b      = b;
        req_shamt  = sh;
        req_valid  = vm;
        #1;
        rdy = req_ready;
        @(posedge clk); #1;
        req_valid = 2'b00;
        edges = 1;
        while (!rsp_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        got = {rsp_id, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_result};
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    logic [1:0]  rdy, vm;
    logic [20:0] got, exp;
    logic [7:0]  opc;
    logic [31:0] av, bv;
    logic [9:0]  shv;
    logic [3:0]  fill_op;
    int          edges, elat, nresp;
    bit          id, seen;

    initial begin
        tbl[0]  = '{2'b01, 4'h5, 16'h0003, 16'h0005, 5'd0,  16'hFFFE, 4'b1010, 2};
        tbl[1]  = '{2'b10, 4'h9, 16'h8000, 16'h0001, 5'd0,  16'h0001, 4'b0000, 2};
        tbl[2]  = '{2'b01, 4'h2, 16'h8000, 16'h0001, 5'd0,  16'h0000, 4'b0100, 2};
        tbl[3]  = '{2'b10, 4'hC, 16'h1111, 16'h2222, 5'd3,  16'h0000, 4'b0101, 2};
        tbl[4]  = '{2'b01, 4'h0, 16'h00FF, 16'h0F0F, 5'd0,  16'h0FF0, 4'b0000, 2};
        tbl[5]  = '{2'b10, 4'h3, 16'h00FF, 16'h0F0F, 5'd0,  16'hF00F, 4'b0010, 2};
        tbl[6]  = '{2'b01, 4'h4, 16'hF0F0, 16'hFF00, 5'd0,  16'hF000, 4'b0010, 2};
        tbl[7]  = '{2'b10, 4'h6, 16'h1200, 16'h0034, 5'd0,  16'h1234, 4'b0000, 2};
        tbl[8]  = '{2'b01, 4'h7, 16'h0005, 16'h0005, 5'd0,  16'h0000, 4'b0100, 2};
        tbl[9]  = '{2'b10, 4'h7, 16'h0005, 16'h0006, 5'd0,  16'h0001, 4'b0000, 2};
        tbl[10] = '{2'b01, 4'h1, 16'h8000, 16'h0000, 5'd15, 16'h0001, 4'b0000, 2};
        tbl[11] = '{2'b10, 4'h1, 16'h8000, 16'h0000, 5'd16, 16'h0000, 4'b0100, 2};
        tbl[12] = '{2'b01, 4'h5, 16'h0005, 16'h0005, 5'd0,  16'h0000, 4'b0100, 2};
        tbl[13] = '{2'b10, 4'h2, 16'h0001, 16'h8000, 5'd0,  16'h0001, 4'b0000, 2};
`ifdef ALU_SCHED_DIV_EN
        tbl[14] = '{2'b01, 4'h8, 16'h0064, 16'h0007, 5'd0,  16'h000E, 4'b0000, 17};
        tbl[15] = '{2'b10, 4'h8, 16'h1234, 16'h0000, 5'd0,  16'h0000, 4'b0100, 17};
`else
        tbl[14] = '{2'b01, 4'h8, 16'h0064, 16'h0007, 5'd0,  16'h0000, 4'b0101, 2};
        tbl[15] = '{2'b10, 4'h8, 16'h1234, 16'h0000, 5'd0,  16'h0000, 4'b0101, 2};
`endif
        tbl[16] = '{2'b01, 4'hF, 16'hABCD, 16'h1234, 5'd1,  16'h0000, 4'b0101, 2};
        tbl[17] = '{2'b10, 4'h5, 16'h0000, 16'h0001, 5'd0,  16'hFFFF, 4'b1010, 2};

        // Reset state, with both requesters asserting valid
        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
        req_opcode = 8'h00; req_a = 32'h0; req_b = 32'h0; req_shamt = 10'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs",
              32'({req_ready, rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_result}),
              32'h0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        m_last = 1'b1;

        // Four back-to-back ties with rsp_ready held high: order 0,1,0,1
        req_opcode = 8'h00;
        req_a = {16'h2222, 16'h1111};
        req_b = 32'h0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        nresp = 0;
        for (int c = 0; c < 40 && nresp < 4; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                check($sformatf("rr order %0d", nresp),
                      32'({rsp_id, rsp_result}),
                      32'({nresp[0], (nresp[0] ? 16'h2222 : 16'h1111)}));
                nresp++;
                if (nresp == 4) req_valid = 2'b00;
            end
        end
        check("rr response count", 32'(nresp), 32'd4);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        m_last = 1'b1;

        // Table vectors; the idle requester's slot carries random noise
        for (int i = 0; i < NV; i++) begin
            id      = tbl[i].vm[1];
            fill_op = 4'($urandom);
            opc = id ? {tbl[i].op, fill_op} : {fill_op, tbl[i].op};
            av  = id ? {tbl[i].a, 16'($urandom)} : {16'($urandom), tbl[i].a};
            bv  = id ? {tbl[i].b, 16'($urandom)} : {16'($urandom), tbl[i].b};
            shv = id ? {tbl[i].sh, 5'($urandom)} : {5'($urandom), tbl[i].sh};
            run_txn(tbl[i].vm, opc, av, bv, shv, rdy, got, edges);
            m_last = id;
            check($sformatf("vec%0d ready", i), 32'(rdy), 32'(tbl[i].vm));
            check($sformatf("vec%0d latency", i), edges, tbl[i].lat);
            check($sformatf("vec%0d rsp", i), 32'(got), 32'({id, tbl[i].fl, tbl[i].res}));
        end

        // Response back-pressure: rsp_ready low for 5 cycles, both requesters pushing
        req_opcode = 8'h50; req_a = 32'h0003_0000; req_b = 32'h0005_0000; req_shamt = 10'h0;
        req_valid = 2'b10;
        @(posedge clk); #1;
        m_last = 1'b1;
        req_valid = 2'b11;
        req_opcode = 8'h66;
        edges = 1;
        while (!rsp_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("stall latency", edges, 2);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall rsp %0d", c),
                  32'({rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_result}),
                  32'({1'b1, 1'b1, 4'b1010, 16'hFFFE}));
            check($sformatf("stall ready %0d", c), 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("after handshake", 32'(rsp_valid), 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 80; k++) begin
            vm  = 2'($urandom_range(1, 3));
            opc = 8'($urandom);
            av  = $urandom;
            bv  = $urandom;
            shv = 10'($urandom);
            if ($urandom_range(0, 7) == 0) bv[15:0]  = 16'h0;
            if ($urandom_range(0, 7) == 0) bv[31:16] = 16'h0;
            if ($urandom_range(0, 3) == 0) av = av & 32'h00FF_00FF;
            id  = (vm == 2'b11) ? ~m_last : vm[1];
            exp = model(id, id ? opc[7:4] : opc[3:0], id ? av[31:16] : av[15:0],
                        id ? bv[31:16] : bv[15:0], id ? shv[9:5] : shv[4:0], elat);
            run_txn(vm, opc, av, bv, shv, rdy, got, edges);
            m_last = id;
            check($sformatf("rand%0d ready", k), 32'(rdy), 32'(id ? 2'b10 : 2'b01));
            check($sformatf("rand%0d latency", k), edges, elat);
            check($sformatf("rand%0d rsp", k), 32'(got), 32'(exp));
        end

        // Reset pulsed while an opcode-8 operation is in flight
        req_opcode = 8'h08; req_a = 32'h0000_0064; req_b = 32'h0000_0007;
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid-op reset outputs",
              32'({req_ready, rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_result}),
              32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_last = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("no response after reset", 32'(seen), 32'd0);
        check("outputs after reset",
              32'({req_ready, rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_result}),
              32'h0);

        // First tie after reset goes to requester 0
        run_txn(2'b11, 8'h55, 32'h0001_0009, 32'h0001_0002, 10'h0, rdy, got, edges);
        check("post-reset tie ready", 32'(rdy), 32'd1);
        check("post-reset tie rsp", 32'(got), 32'({1'b0, 4'b0000, 16'h0007}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
